fft_ctrl: RTL and testbench
===========================

# fft_ctrl

In-place radix-2 decimation-in-time FFT sequencer for the packed-complex butterfly datapath. It steps a single shared butterfly through all `LOG2N` stages of an `N = 2**LOG2N` point transform held in a dual-port data RAM. Each cycle it issues the read addresses for one butterfly, the twiddle ROM address, and the delayed write-back addresses. It sits between the data RAM / twiddle ROM and the butterfly; upstream loads samples in bit-reversed order, and results are left in natural order.

## Interface
- `LOG2N`, 4: log2 of transform length; legal 2..10.
- `AW`, `LOG2N`: data RAM address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `inv` in 1: inverse-transform select; latched when `start` is accepted.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle completion pulse.
- `rd_en` out 1: read strobe, both RAM ports.
- `rd_addr_a` out AW: address of butterfly input x1.
- `rd_addr_b` out AW: address of butterfly input x2.
- `tw_addr` out LOG2N-1: twiddle ROM address, 1-cycle synchronous ROM.
- `bf_inv` out 1: latched `inv`, driven to the butterfly `inv` input.
- `wr_en` out 1: write strobe for butterfly outputs y1/y2.
- `wr_addr_a` out AW: destination of y1.
- `wr_addr_b` out AW: destination of y2.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `start`=1. On that edge, latch `inv` into `bf_inv` and clear stage `s` and butterfly index `k`.
- RUN issues one butterfly per cycle, `k` = 0..N/2-1.
- After `k`=N/2-1, RUN -> DRAIN. DRAIN is one bubble cycle with no read, so the last write of stage `s` lands before stage `s+1` reads.
- DRAIN -> RUN with `s+1`, `k`=0, if `s` < LOG2N-1; otherwise DRAIN -> DONE.
- DONE -> IDLE after one cycle. `done`=1 only in DONE.
- Address generation for stage `s` and index `k`:
  - `half` = 1<<s, `j` = k & (half-1), `g` = k>>s.
  - `rd_addr_a` = g*2*half + j.
  - `rd_addr_b` = `rd_addr_a` + half.
  - `tw_addr` = j << (LOG2N-1-s).
  - All values are unsigned, computed with shifts and masks; no multipliers.
- `rd_en`, `rd_addr_a/b` and `tw_addr` are registered outputs.
- `wr_en` and `wr_addr_a/b` are the `rd_en`/`rd_addr` registers delayed by exactly one cycle. Write-back therefore coincides with RAM/ROM read data being valid and the combinational butterfly result.
- `start` in any state other than IDLE is ignored. `inv` changes after acceptance have no effect.
- `start` held high through DONE starts a new transform on the edge it is sampled in IDLE. There are no back-to-back transforms without an IDLE cycle.
- `busy` = 1 in RUN and DRAIN, 0 in IDLE and DONE.

## Timing
- Reset values: all outputs 0, state IDLE, `s`=0, `k`=0, `bf_inv`=0.
- Reset asserted mid-transform:
  - All outputs go to 0 immediately (asynchronous), including `wr_en`, so no pending write completes.
  - The transform is abandoned and RAM contents are undefined.
- Cycle 0 is the edge where `start` is sampled.
- Cycles 1..N/2: stage 0 reads. Cycles 2..N/2+1: stage 0 writes.
- Each stage takes N/2+1 cycles, including DRAIN.
- The last write occurs in cycle LOG2N*(N/2+1). For N=16 this is cycle 36.
- `done` is high in cycle LOG2N*(N/2+1)+1 (cycle 37 for N=16); `busy` falls at the same time.
- The next `start` is accepted at cycle +2 at the earliest.
- `wr_en` is never high in the same cycle as a `rd_en` that addresses the same location.

## Test plan
- **Reset:**
  - Drive `rst_n`=0 with `start`=1 -> all outputs 0, no `rd_en`.
  - Release reset -> still IDLE until the next sampled `start`.
- **Address trace, N=16:**
  - Stage 0, k=0,1 -> (a,b,tw) = (0,1,0), (2,3,0).
  - Stage 1, k=1 -> (1,3,4).
  - Stage 3, k=3 -> (3,11,3).
  - Each write address pair appears exactly 1 cycle after its read.
- **Latency and stage bubble:**
  - Count cycles from `start` -> `rd_en` low in cycles 9, 18, 27, 36.
  - Last `wr_en` in cycle 36, `done` single pulse in cycle 37, `busy` high cycles 1..36.
- **End-to-end with butterfly, 16-word RAM and twiddle ROM:**
  - Input addr0 = 0x01000000, all others 0 (impulse).
  - Required result: all 16 words = 0x01000000, for both `inv`=0 and `inv`=1.
- **Inv latch and start filtering:**
  - Start with `inv`=1, toggle `inv` and pulse `start` during RUN.
  - Required: `bf_inv` stays 1 throughout, no restart, `done` at cycle 37 only.
- **Reset mid-operation:**
  - Assert `rst_n`=0 in cycle 20 -> `wr_en`, `rd_en`, `busy` go 0 asynchronously, no `done`.
  - A new `start` after release runs a full 37-cycle transform.

Source files
------------

// File: rtl/fft_ctrl.sv
`timescale 1ns/1ps
// fft_ctrl: address/strobe sequencer for an in-place radix-2 DIT FFT with one shared butterfly.
// One butterfly is read per cycle; write-back addresses trail the reads by exactly one cycle.
module fft_ctrl #(
  parameter int LOG2N = 4,
  parameter int AW    = LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_inv,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   s_r, s_s;
  logic [KW-1:0]   k_r, k_s;
  logic            inv_s;
  logic [AW-1:0]   half_s, j_s, g_s, a_s, b_s;
  logic [KW-1:0]   tw_s;

  // Next-state logic: stage/butterfly counters and the inverse-select latch.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    k_s     = k_r;
    inv_s   = bf_inv;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          s_s     = '0;
          k_s     = '0;
          inv_s   = inv;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == K_LAST) begin
          state_s = DRAIN;
          k_s     = '0;
        end else begin
          k_s = k_r + KW'(1'b1);
        end
      end
      DRAIN: begin
        if (s_r == S_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
          s_s     = s_r + SW'(1'b1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Butterfly addressing: the low s bits of k select the position inside a group,
  // the high bits select the group; the group base is k's high bits shifted up by one.
  always_comb begin
    half_s = AW'(1'b1) << s_r;
    j_s    = AW'(k_r) & (half_s - AW'(1'b1));
    g_s    = AW'(k_r) >> s_r;
    a_s    = ((g_s << s_r) << 1'b1) | j_s;
    b_s    = a_s | half_s;
    tw_s   = KW'(j_s << (KW - int'(s_r)));
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s_r     <= '0;
      k_r     <= '0;
      bf_inv  <= 1'b0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      k_r     <= k_s;
      bf_inv  <= inv_s;
    end
  end

  // Registered read/write strobes and addresses; the write side is the read side one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en     <= (state_r == RUN);
      rd_addr_a <= (state_r == RUN) ? a_s : '0;
      rd_addr_b <= (state_r == RUN) ? b_s : '0;
      tw_addr   <= (state_r == RUN) ? tw_s : '0;
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
      busy      <= (state_r == RUN) || (state_r == DRAIN);
      done      <= (state_r == DONE);
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for fft_ctrl (N=16): cycle-accurate trace model, impulse FFT through a
// behavioural butterfly/RAM/ROM, start/inv filtering, asynchronous reset and back-to-back starts.
module tb_fft_ctrl;

  localparam int LOG2N   = 4;
  localparam int N       = 16;
  localparam int HALFN   = 8;
  localparam int LAST_WR = LOG2N * (HALFN + 1);

  logic       clk = 1'b0;
  logic       rst_n, start, inv;
  logic       busy, done, rd_en, wr_en, bf_inv;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;

  int vectors = 0;
  int miscompares = 0;

  logic       e_rd [64], e_wr [64];
  logic [3:0] e_a [64], e_b [64], e_wa [64], e_wb [64];
  logic [2:0] e_tw [64];
  logic       cap_rd [64], cap_wr [64], cap_busy [64], cap_done [64];
  logic [3:0] cap_a [64], cap_b [64], cap_wa [64], cap_wb [64];
  logic [2:0] cap_tw [64];

  logic [31:0] mem [16];
  logic [31:0] rd_a_q, rd_b_q, tw_q;
  logic [63:0] bf_out;
  logic        mem_init = 1'b0;

  fft_ctrl #(.LOG2N(LOG2N), .AW(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inv(inv),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_inv(bf_inv), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  // Q15 twiddles W^t = cos(2*pi*t/16) - j*sin(2*pi*t/16), packed {re, im}
  function automatic logic [31:0] tw_rom(input logic [2:0] t);
    case (t)
      3'd0:    return {16'h7FFF, 16'h0000};
      3'd1:    return {16'h7642, 16'hCF04};
      3'd2:    return {16'h5A82, 16'hA57E};
      3'd3:    return {16'h30FC, 16'h89BE};
      3'd4:    return {16'h0000, 16'h8001};
      3'd5:    return {16'hCF04, 16'h89BE};
      3'd6:    return {16'hA57E, 16'hA57E};
      3'd7:    return {16'h89BE, 16'hCF04};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] bfly(input logic [31:0] x1, input logic [31:0] x2,
                                        input logic [31:0] w, input logic iv);
    logic signed [15:0] ar, ai, br, bi, wre, wim;
    logic signed [31:0] pr, pim;
    logic [15:0] y1r, y1i, y2r, y2i;
    ar  = x1[31:16]; ai = x1[15:0];
    br  = x2[31:16]; bi = x2[15:0];
    wre = w[31:16];
    wim = iv ? 16'(-$signed(w[15:0])) : w[15:0];
    pr  = (32'(br) * 32'(wre) - 32'(bi) * 32'(wim)) >>> 15;
    pim = (32'(br) * 32'(wim) + 32'(bi) * 32'(wre)) >>> 15;
    y1r = 16'(ar + pr[15:0]);  y1i = 16'(ai + pim[15:0]);
    y2r = 16'(ar - pr[15:0]);  y2i = 16'(ai - pim[15:0]);
    return {y1r, y1i, y2r, y2i};
  endfunction

  always_comb bf_out = bfly(rd_a_q, rd_b_q, tw_q, bf_inv);

  // Data RAM (sync read), twiddle ROM (sync read) and butterfly write-back
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h01000000;
    end else if (wr_en) begin
      mem[wr_addr_a] <= bf_out[63:32];
      mem[wr_addr_b] <= bf_out[31:0];
    end
    if (rd_en) begin
      rd_a_q <= mem[rd_addr_a];
      rd_b_q <= mem[rd_addr_b];
    end
    tw_q <= tw_rom(tw_addr);
  end

  // Expected schedule from the transform definition: stage s, butterfly k read in cycle s*(N/2+1)+k+1
  task automatic build_model();
    int c, half;
    for (int n = 0; n < 64; n++) begin
      e_rd[n] = 1'b0; e_wr[n] = 1'b0;
      e_a[n] = 4'd0; e_b[n] = 4'd0; e_wa[n] = 4'd0; e_wb[n] = 4'd0; e_tw[n] = 3'd0;
    end
    for (int s = 0; s < LOG2N; s++) begin
      half = 2 ** s;
      for (int k = 0; k < HALFN; k++) begin
        c = s * (HALFN + 1) + k + 1;
        e_rd[c]   = 1'b1;
        e_a[c]    = 4'((k / half) * 2 * half + (k % half));
        e_b[c]    = 4'((k / half) * 2 * half + (k % half) + half);
        e_tw[c]   = 3'((k % half) * (2 ** (LOG2N - 1 - s)));
        e_wr[c+1] = 1'b1;
        e_wa[c+1] = e_a[c];
        e_wb[c+1] = e_b[c];
      end
    end
  endtask

  // Runs one transform from IDLE and compares every output in cycles 1..40
  task automatic run_transform(input logic inv_v, input bit noise);
    logic eb, ed;
    build_model();
    start = 1'b1; inv = inv_v;
    @(posedge clk); #1;
    start = 1'b0; inv = ~inv_v;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      cap_rd[n] = rd_en; cap_wr[n] = wr_en; cap_busy[n] = busy; cap_done[n] = done;
      cap_a[n] = rd_addr_a; cap_b[n] = rd_addr_b; cap_tw[n] = tw_addr;
      cap_wa[n] = wr_addr_a; cap_wb[n] = wr_addr_b;
      eb = (n >= 1) && (n <= LAST_WR);
      ed = (n == LAST_WR + 1);
      vectors++;
      if ({rd_en, wr_en, busy, done, bf_inv} !== {e_rd[n], e_wr[n], eb, ed, inv_v}) begin
        miscompares++;
        $display("FAIL ctrl cycle %0d: rd/wr/busy/done/inv got %b%b%b%b%b want %b%b%b%b%b", n,
                 rd_en, wr_en, busy, done, bf_inv, e_rd[n], e_wr[n], eb, ed, inv_v);
      end
      if (e_rd[n]) begin
        vectors++;
        if ({rd_addr_a, rd_addr_b, tw_addr} !== {e_a[n], e_b[n], e_tw[n]}) begin
          miscompares++;
          $display("FAIL rd_addr cycle %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", n,
                   rd_addr_a, rd_addr_b, tw_addr, e_a[n], e_b[n], e_tw[n]);
        end
      end
      if (e_wr[n]) begin
        vectors++;
        if ({wr_addr_a, wr_addr_b} !== {e_wa[n], e_wb[n]}) begin
          miscompares++;
          $display("FAIL wr_addr cycle %0d: got (%0d,%0d) want (%0d,%0d)", n,
                   wr_addr_a, wr_addr_b, e_wa[n], e_wb[n]);
        end
      end
      if (rd_en === 1'b1 && wr_en === 1'b1) begin
        vectors++;
        if (rd_addr_a == wr_addr_a || rd_addr_a == wr_addr_b ||
            rd_addr_b == wr_addr_a || rd_addr_b == wr_addr_b) begin
          miscompares++;
          $display("FAIL rw_overlap cycle %0d: rd (%0d,%0d) wr (%0d,%0d) want disjoint", n,
                   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b);
        end
      end
      if (noise && n >= 2 && n <= 30) begin
        start = (n == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        inv   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; inv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy, done, rd_en, wr_en, bf_inv, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 24'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b bf_inv=%b want all 0",
                 busy, done, rd_en, wr_en, bf_inv);
      end
    end
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy, done, rd_en} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_release_idle: busy/done/rd_en got %b%b%b want 000", busy, done, rd_en);
      end
    end
  endtask

  task automatic test_address_trace();
    int         cyc [4];
    logic [3:0] ea [4], eb [4];
    logic [2:0] et [4];
    cyc = '{1, 2, 11, 31};
    ea  = '{4'd0, 4'd2, 4'd1, 4'd3};
    eb  = '{4'd1, 4'd3, 4'd3, 4'd11};
    et  = '{3'd0, 3'd0, 3'd4, 3'd3};
    run_transform(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({cap_rd[cyc[i]], cap_a[cyc[i]], cap_b[cyc[i]], cap_tw[cyc[i]]} !== {1'b1, ea[i], eb[i], et[i]}) begin
        miscompares++;
        $display("FAIL trace_rd cycle %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", cyc[i],
                 cap_a[cyc[i]], cap_b[cyc[i]], cap_tw[cyc[i]], ea[i], eb[i], et[i]);
      end
      vectors++;
      if ({cap_wr[cyc[i]+1], cap_wa[cyc[i]+1], cap_wb[cyc[i]+1]} !== {1'b1, ea[i], eb[i]}) begin
        miscompares++;
        $display("FAIL trace_wr cycle %0d: got (%0d,%0d) want (%0d,%0d)", cyc[i] + 1,
                 cap_wa[cyc[i]+1], cap_wb[cyc[i]+1], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_latency();
    run_transform(1'($urandom_range(0, 1)), 1'b0);
    for (int st = 1; st <= LOG2N; st++) begin
      vectors++;
      if (cap_rd[st * 9] !== 1'b0) begin
        miscompares++;
        $display("FAIL bubble cycle %0d: rd_en got %b want 0", st * 9, cap_rd[st * 9]);
      end
    end
    vectors++;
    if ({cap_wr[36], cap_wr[37], cap_wr[38]} !== 3'b100) begin
      miscompares++;
      $display("FAIL last_write: wr_en 36..38 got %b%b%b want 100", cap_wr[36], cap_wr[37], cap_wr[38]);
    end
    vectors++;
    if ({cap_done[36], cap_done[37], cap_done[38], cap_busy[1], cap_busy[36], cap_busy[37]} !== 6'b010110) begin
      miscompares++;
      $display("FAIL done_busy_edges: done36..38=%b%b%b busy1/36/37=%b%b%b want 010 110",
               cap_done[36], cap_done[37], cap_done[38], cap_busy[1], cap_busy[36], cap_busy[37]);
    end
  endtask

  task automatic test_e2e(input logic inv_v);
    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    run_transform(inv_v, 1'b0);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mem[i] !== 32'h01000000) begin
        miscompares++;
        $display("FAIL impulse inv=%0d word %0d: got %h want 01000000", inv_v, i, mem[i]);
      end
    end
  endtask

  task automatic test_inv_latch();
    run_transform(1'b1, 1'b1);
    run_transform(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic r;
    r = 1'($urandom_range(0, 1));
    build_model();
    start = 1'b1; inv = r;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if ({rd_en, wr_en, busy} !== {e_rd[20], e_wr[20], 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset cycle 20: rd/wr/busy got %b%b%b want %b%b1", rd_en, wr_en, busy, e_rd[20], e_wr[20]);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rd_en, wr_en, busy, done, bf_inv} !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_reset: rd/wr/busy/done/inv got %b%b%b%b%b want 00000", rd_en, wr_en, busy, done, bf_inv);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({rd_en, wr_en, busy, done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL held_reset: rd/wr/busy/done got %b%b%b%b want 0000", rd_en, wr_en, busy, done);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_transform(~r, 1'b0);
  endtask

  task automatic test_back_to_back();
    int rise, done_at;
    rise = 0; done_at = 0;
    start = 1'b1; inv = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (n <= 38) begin
        vectors++;
        if ({done, busy} !== {n == 37, (n >= 1) && (n <= 36)}) begin
          miscompares++;
          $display("FAIL b2b_first cycle %0d: done/busy got %b%b want %b%b", n, done, busy, n == 37, (n >= 1) && (n <= 36));
        end
      end
      if (n == 37 || n == 38) begin
        vectors++;
        if (rd_en !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_gap cycle %0d: rd_en got %b want 0", n, rd_en);
        end
      end
      if (n > 38 && rise == 0 && busy === 1'b1) rise = n;
      start = (n < 40);
    end
    vectors++;
    if (rise < 39 || rise > 42) begin
      miscompares++;
      $display("FAIL b2b_restart: busy rose in cycle %0d want 39..42", rise);
    end
    for (int n = 46; n <= 100 && done_at == 0; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_at = n;
    end
    vectors++;
    if (rise == 0 || done_at != rise + 36) begin
      miscompares++;
      $display("FAIL b2b_second_done: done in cycle %0d want %0d", done_at, rise + 36);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_address_trace();
    test_latency();
    test_e2e(1'b0);
    test_e2e(1'b1);
    test_inv_latch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
